// File: rtl/rgb_frame_monitor.sv
// rgb_frame_monitor
// Tracks the X/Y position of a valid-qualified multi-channel pixel stream.
// It pulses line and frame strobes and latches a checksum and a frame count for each frame.
// Any pixel that arrives after a one-shot frame has completed is flagged as an overrun.
//
// state  | meaning
// IDLE   | armed, waiting for the first pixel of a frame
// ACTIVE | frame in progress, pixels accumulate into the checksum
// DONE   | one-shot frame complete; pixels count as overruns until clear
module rgb_frame_monitor #(
   parameter int IMG_WIDTH  = 400,
   parameter int IMG_HEIGHT = 300,
   parameter int CH_WIDTH   = 8,
   parameter int NUM_CH     = 3,
   parameter int CKSUM_W    = 32,
   parameter int CONTINUOUS = 0
) (
   input  logic                           pixclk,
   input  logic                           reset,
   input  logic                           valid,
   input  logic [NUM_CH*CH_WIDTH-1:0]     iData,
   input  logic                           clear,
   output logic [$clog2(IMG_WIDTH)-1:0]   x_coord,
   output logic [$clog2(IMG_HEIGHT)-1:0]  y_coord,
   output logic                           line_done,
   output logic                           frame_done,
   output logic                           busy,
   output logic [15:0]                    frame_cnt,
   output logic [CKSUM_W-1:0]             checksum,
   output logic                           overrun_err,
   output logic [15:0]                    overrun_cnt
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                       state;
   logic                         v_r;
   logic [NUM_CH*CH_WIDTH-1:0]   d_r;
   logic [CKSUM_W-1:0]           acc;
   logic [CKSUM_W-1:0]           pix_sum;

   // Input stage: register the stream unconditionally so all decisions see a clean, aligned pixel.
   always_ff @(posedge pixclk or negedge reset) begin
      if (!reset) begin
         v_r <= 1'b0;
         d_r <= '0;
      end else begin
         v_r <= valid;
         d_r <= iData;
      end
   end

   // Sum of the registered pixel's channels, each zero-extended, wrapped to the checksum width.
   always_comb begin
      pix_sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pix_sum = pix_sum + CKSUM_W'(d_r[i*CH_WIDTH +: CH_WIDTH]);
      end
   end

   // Frame FSM with coordinate tracking, strobes, checksum latch and overrun accounting.
   always_ff @(posedge pixclk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         x_coord     <= '0;
         y_coord     <= '0;
         line_done   <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
         checksum    <= '0;
         acc         <= '0;
         overrun_err <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         line_done  <= 1'b0;
         frame_done <= 1'b0;
         if (clear) begin
            // A pixel coinciding with clear is dropped; checksum and frame count survive.
            state       <= IDLE;
            x_coord     <= '0;
            y_coord     <= '0;
            busy        <= 1'b0;
            acc         <= '0;
            overrun_err <= 1'b0;
            overrun_cnt <= '0;
         end else begin
            case (state)
               IDLE, ACTIVE: begin
                  if (v_r) begin
                     if (x_coord == X_LAST) begin
                        x_coord   <= '0;
                        line_done <= 1'b1;
                        if (y_coord == Y_LAST) begin
                           y_coord    <= '0;
                           frame_done <= 1'b1;
                           checksum   <= acc + pix_sum;
                           acc        <= '0;
                           frame_cnt  <= frame_cnt + 16'd1;
                           busy       <= 1'b0;
                           state      <= (CONTINUOUS != 0) ? IDLE : DONE;
                        end else begin
                           y_coord <= y_coord + YW'(1);
                           acc     <= acc + pix_sum;
                           busy    <= 1'b1;
                           state   <= ACTIVE;
                        end
                     end else begin
                        x_coord <= x_coord + XW'(1);
                        acc     <= acc + pix_sum;
                        busy    <= 1'b1;
                        state   <= ACTIVE;
                     end
                  end
               end
               DONE: begin
                  if (v_r) begin
                     overrun_err <= 1'b1;
                     if (overrun_cnt != 16'hFFFF) begin
                        overrun_cnt <= overrun_cnt + 16'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rgb_frame_monitor.sv
// Bench for rgb_frame_monitor. It runs three instances that share one stimulus stream:
// one-shot with a 32-bit checksum, continuous with a 32-bit checksum, and one-shot with an 8-bit checksum.
// The reference model counts pixels per frame and derives the expected coordinates from that index.
module tb_rgb_frame_monitor;

   localparam int W = 4;
   localparam int H = 2;

   logic        pixclk = 1'b0;
   logic        reset  = 1'b0;
   logic        valid  = 1'b0;
   logic        clear  = 1'b0;
   logic [23:0] iData  = '0;

   logic [1:0]  xc [3];
   logic        yc [3];
   logic        ld [3];
   logic        fd [3];
   logic        bz [3];
   logic        oe [3];
   logic [15:0] fc [3];
   logic [15:0] oc [3];
   logic [31:0] ck0, ck1;
   logic [7:0]  ck2;
   logic [31:0] ckv [3];

   int checks = 0;
   int errors = 0;

   int              m_n [3];
   int              m_frames [3];
   int              m_ocnt [3];
   longint unsigned m_acc [3];
   longint unsigned m_cks [3];
   bit              m_done [3];
   bit              m_busy [3];
   bit              m_line [3];
   bit              m_frame [3];
   bit              m_oerr [3];
   bit              pv;
   logic [23:0]     pd;

   always #5 pixclk = ~pixclk;

   always_comb begin
      ckv[0] = ck0;
      ckv[1] = ck1;
      ckv[2] = {24'd0, ck2};
   end

   rgb_frame_monitor #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CH_WIDTH(8), .NUM_CH(3),
                       .CKSUM_W(32), .CONTINUOUS(0)) u_a (
      .pixclk(pixclk), .reset(reset), .valid(valid), .iData(iData), .clear(clear),
      .x_coord(xc[0]), .y_coord(yc[0]), .line_done(ld[0]), .frame_done(fd[0]),
      .busy(bz[0]), .frame_cnt(fc[0]), .checksum(ck0), .overrun_err(oe[0]),
      .overrun_cnt(oc[0]));

   rgb_frame_monitor #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CH_WIDTH(8), .NUM_CH(3),
                       .CKSUM_W(32), .CONTINUOUS(1)) u_b (
      .pixclk(pixclk), .reset(reset), .valid(valid), .iData(iData), .clear(clear),
      .x_coord(xc[1]), .y_coord(yc[1]), .line_done(ld[1]), .frame_done(fd[1]),
      .busy(bz[1]), .frame_cnt(fc[1]), .checksum(ck1), .overrun_err(oe[1]),
      .overrun_cnt(oc[1]));

   rgb_frame_monitor #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CH_WIDTH(8), .NUM_CH(3),
                       .CKSUM_W(8), .CONTINUOUS(0)) u_c (
      .pixclk(pixclk), .reset(reset), .valid(valid), .iData(iData), .clear(clear),
      .x_coord(xc[2]), .y_coord(yc[2]), .line_done(ld[2]), .frame_done(fd[2]),
      .busy(bz[2]), .frame_cnt(fc[2]), .checksum(ck2), .overrun_err(oe[2]),
      .overrun_cnt(oc[2]));

   function automatic int psum(input logic [23:0] d);
      return int'(d[7:0]) + int'(d[15:8]) + int'(d[23:16]);
   endfunction

   function automatic longint unsigned cks_mask(input int k);
      return (k == 2) ? 64'hFF : 64'hFFFF_FFFF;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_n[k] = 0; m_frames[k] = 0; m_ocnt[k] = 0; m_acc[k] = 0; m_cks[k] = 0;
         m_done[k] = 0; m_busy[k] = 0; m_line[k] = 0; m_frame[k] = 0; m_oerr[k] = 0;
      end
      pv = 0;
      pd = '0;
   endtask

   // Expected effect of one clock edge; pv/pd hold the pixel seen on the previous edge.
   task automatic model_step(input bit v, input logic [23:0] d, input bit c);
      for (int k = 0; k < 3; k++) begin
         m_line[k]  = 0;
         m_frame[k] = 0;
         if (c) begin
            m_n[k] = 0; m_acc[k] = 0; m_oerr[k] = 0; m_ocnt[k] = 0; m_done[k] = 0; m_busy[k] = 0;
         end else if (pv) begin
            if (m_done[k]) begin
               m_oerr[k] = 1;
               if (m_ocnt[k] < 65535) m_ocnt[k]++;
            end else begin
               m_acc[k] += longint'(psum(pd));
               m_n[k]++;
               m_busy[k] = 1;
               if (m_n[k] % W == 0) m_line[k] = 1;
               if (m_n[k] == W * H) begin
                  m_frame[k]  = 1;
                  m_cks[k]    = m_acc[k] & cks_mask(k);
                  m_acc[k]    = 0;
                  m_n[k]      = 0;
                  m_busy[k]   = 0;
                  m_frames[k] = (m_frames[k] + 1) % 65536;
                  m_done[k]   = (k != 1);
               end
            end
         end
      end
      pv = v;
      pd = d;
   endtask

   // Called at a falling edge; returns at the next falling edge with outputs settled.
   task automatic tick(input bit v, input logic [23:0] d, input bit c);
      valid = v;
      iData = d;
      clear = c;
      @(posedge pixclk);
      model_step(v, d, c);
      @(negedge pixclk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      valid = 1'b0;
      clear = 1'b0;
      iData = '0;
      model_reset();
      @(negedge pixclk);
      @(negedge pixclk);
      reset = 1'b1;
      @(negedge pixclk);
   endtask

   task automatic test_reset();
      @(negedge pixclk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (xc[k] !== 2'd0 || yc[k] !== 1'b0) begin
            errors++; $display("FAIL reset_coord dut%0d: got x=%0d y=%0d expected 0 0", k, xc[k], yc[k]);
         end
         checks++;
         if (ld[k] !== 1'b0 || fd[k] !== 1'b0 || bz[k] !== 1'b0) begin
            errors++; $display("FAIL reset_flags dut%0d: got ld=%b fd=%b busy=%b expected 0 0 0", k, ld[k], fd[k], bz[k]);
         end
         checks++;
         if (fc[k] !== 16'd0 || ckv[k] !== 32'd0 || oe[k] !== 1'b0 || oc[k] !== 16'd0) begin
            errors++; $display("FAIL reset_regs dut%0d: got fc=%0d ck=%0d oe=%b oc=%0d expected 0", k, fc[k], ckv[k], oe[k], oc[k]);
         end
      end
      reset = 1'b1;
      model_reset();
      @(negedge pixclk);
   endtask

   task automatic test_frame();
      int lcyc[$];
      int fcyc[$];
      do_reset();
      for (int i = 0; i < 12; i++) begin
         tick(i < 8, (i < 8) ? 24'h010101 : 24'h0, 1'b0);
         if (ld[0]) lcyc.push_back(i);
         if (fd[0]) fcyc.push_back(i);
         checks++;
         if (xc[0] !== 2'(m_n[0] % W) || yc[0] !== 1'(m_n[0] / W)) begin
            errors++; $display("FAIL frame_coord cyc %0d: got (%0d,%0d) expected (%0d,%0d)", i, xc[0], yc[0], m_n[0] % W, m_n[0] / W);
         end
      end
      checks++;
      if (lcyc.size() != 2 || lcyc[1] - lcyc[0] != 4) begin
         errors++; $display("FAIL frame_lines: got %0d pulses spaced %0d expected 2 spaced 4", lcyc.size(), lcyc[1] - lcyc[0]);
      end
      checks++;
      if (fcyc.size() != 1 || fcyc[0] != lcyc[1]) begin
         errors++; $display("FAIL frame_done_align: got %0d pulses at %0d expected 1 at %0d", fcyc.size(), fcyc[0], lcyc[1]);
      end
      checks++;
      if (ck0 !== 32'd24 || fc[0] !== 16'd1 || bz[0] !== 1'b0) begin
         errors++; $display("FAIL frame_result: got ck=%0d fc=%0d busy=%b expected 24 1 0", ck0, fc[0], bz[0]);
      end
   endtask

   task automatic test_gaps();
      int lcyc[$];
      int highs;
      highs = 0;
      tick(1'b0, 24'h0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick((i < 16) && (i % 2 == 0), 24'h010101, 1'b0);
         if (ld[0]) begin lcyc.push_back(i); highs++; end
         checks++;
         if (xc[0] !== 2'(m_n[0] % W) || yc[0] !== 1'(m_n[0] / W) || ld[0] !== m_line[0] || fd[0] !== m_frame[0]) begin
            errors++; $display("FAIL gaps_cycle %0d: got (%0d,%0d) ld=%b fd=%b expected (%0d,%0d) ld=%b fd=%b",
                               i, xc[0], yc[0], ld[0], fd[0], m_n[0] % W, m_n[0] / W, m_line[0], m_frame[0]);
         end
      end
      checks++;
      if (highs != 2 || lcyc[0] != 7 || lcyc[1] != 15) begin
         errors++; $display("FAIL gaps_lines: got %0d high cycles first at %0d expected 2 at 7 and 15", highs, lcyc[0]);
      end
      checks++;
      if (ck0 !== 32'd24 || fc[0] !== 16'd2) begin
         errors++; $display("FAIL gaps_result: got ck=%0d fc=%0d expected 24 2", ck0, fc[0]);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int i = 0; i < 10; i++) tick(i < 8, 24'h010101, 1'b0);
      for (int i = 0; i < 5; i++) tick(i < 3, 24'h0A0B0C, 1'b0);
      checks++;
      if (oe[0] !== 1'b1 || oc[0] !== 16'd3) begin
         errors++; $display("FAIL overrun_count: got oe=%b oc=%0d expected 1 3", oe[0], oc[0]);
      end
      checks++;
      if (xc[0] !== 2'd0 || yc[0] !== 1'b0 || ck0 !== 32'd24 || bz[0] !== 1'b0) begin
         errors++; $display("FAIL overrun_hold: got (%0d,%0d) ck=%0d busy=%b expected (0,0) 24 0", xc[0], yc[0], ck0, bz[0]);
      end
      tick(1'b0, 24'h0, 1'b1);
      checks++;
      if (oe[0] !== 1'b0 || oc[0] !== 16'd0 || fc[0] !== 16'd1 || ck0 !== 32'd24) begin
         errors++; $display("FAIL overrun_clear: got oe=%b oc=%0d fc=%0d ck=%0d expected 0 0 1 24", oe[0], oc[0], fc[0], ck0);
      end
      // A pixel landing on the clear cycle must vanish.
      tick(1'b1, 24'h050505, 1'b0);
      tick(1'b0, 24'h0, 1'b1);
      tick(1'b0, 24'h0, 1'b0);
      checks++;
      if (xc[0] !== 2'd0 || bz[0] !== 1'b0 || oc[0] !== 16'd0) begin
         errors++; $display("FAIL clear_discard: got x=%0d busy=%b oc=%0d expected 0 0 0", xc[0], bz[0], oc[0]);
      end
   endtask

   task automatic test_continuous();
      longint unsigned seen[$];
      int fcyc[$];
      do_reset();
      for (int i = 0; i < 19; i++) begin
         tick(i < 16, (i < 16) ? 24'(i + 1) : 24'h0, 1'b0);
         if (fd[1]) begin seen.push_back(longint'(ck1)); fcyc.push_back(i); end
      end
      checks++;
      if (seen.size() != 2 || seen[0] != 36 || seen[1] != 100) begin
         errors++; $display("FAIL cont_cksum: got %0d pulses ck %0d,%0d expected 2 pulses 36,100", seen.size(), seen[0], seen[1]);
      end
      checks++;
      if (fcyc[1] - fcyc[0] != 8 || fc[1] !== 16'd2 || oc[1] !== 16'd0 || oe[1] !== 1'b0) begin
         errors++; $display("FAIL cont_state: got gap=%0d fc=%0d oc=%0d oe=%b expected 8 2 0 0", fcyc[1] - fcyc[0], fc[1], oc[1], oe[1]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 10; i++) tick(i < 8, 24'hFFFFFF, 1'b0);
      checks++;
      if (ck2 !== 8'hE8 || fc[2] !== 16'd1) begin
         errors++; $display("FAIL wrap_cksum8: got ck=%0h fc=%0d expected e8 1", ck2, fc[2]);
      end
      checks++;
      if (ck0 !== 32'd6120) begin
         errors++; $display("FAIL wrap_cksum32: got %0d expected 6120", ck0);
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] px;
      int          total;
      do_reset();
      for (int i = 0; i < 10; i++) tick(i < 8, 24'($urandom), 1'b0);
      tick(1'b0, 24'h0, 1'b1);
      for (int i = 0; i < 6; i++) tick(1'b1, 24'($urandom), 1'b0);
      reset = 1'b0;
      model_reset();
      #1;
      checks++;
      if (xc[0] !== 2'd0 || yc[0] !== 1'b0 || bz[0] !== 1'b0 || fc[0] !== 16'd0 || ck0 !== 32'd0) begin
         errors++; $display("FAIL reset_mid: got (%0d,%0d) busy=%b fc=%0d ck=%0d expected all 0", xc[0], yc[0], bz[0], fc[0], ck0);
      end
      @(negedge pixclk);
      reset = 1'b1;
      valid = 1'b0;
      @(negedge pixclk);
      total = 0;
      for (int i = 0; i < 10; i++) begin
         px = 24'($urandom);
         if (i < 8) total += psum(px);
         tick(i < 8, px, 1'b0);
      end
      checks++;
      if (ck0 !== 32'(total) || fc[0] !== 16'd1) begin
         errors++; $display("FAIL reset_mid_frame: got ck=%0d fc=%0d expected %0d 1", ck0, fc[0], total);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         tick($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 39) == 0);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (xc[k] !== 2'(m_n[k] % W) || yc[k] !== 1'(m_n[k] / W) || ld[k] !== m_line[k] ||
                fd[k] !== m_frame[k] || bz[k] !== m_busy[k] || fc[k] !== 16'(m_frames[k]) ||
                ckv[k] !== 32'(m_cks[k]) || oe[k] !== m_oerr[k] || oc[k] !== 16'(m_ocnt[k])) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d: got x=%0d y=%0d ld=%b fd=%b bz=%b fc=%0d ck=%0d oe=%b oc=%0d expected x=%0d y=%0d ld=%b fd=%b bz=%b fc=%0d ck=%0d oe=%b oc=%0d",
                        k, i, xc[k], yc[k], ld[k], fd[k], bz[k], fc[k], ckv[k], oe[k], oc[k],
                        m_n[k] % W, m_n[k] / W, m_line[k], m_frame[k], m_busy[k], m_frames[k], m_cks[k], m_oerr[k], m_ocnt[k]);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_frame();
      test_gaps();
      test_overrun();
      test_continuous();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_frame_monitor.md
# rgb_frame_monitor

Synthesizable, parametrised frame monitor for the pixel-stream side of the VFP pipeline: tracks pixel X/Y coordinates of a valid-qualified multi-channel stream, generates line/frame-done strobes, latches a per-frame checksum and frame count, and flags pixels arriving after a frame completes. It replaces the simulation-only coordinate tracker with an on-chip block. It can sit on either the camera (d5m) capture stream or the mm2s read-back stream, so both paths can be checked in hardware and in the testbench.

## Interface
- IMG_WIDTH, 400, active pixels per line (≥2)
- IMG_HEIGHT, 300, lines per frame (≥2)
- CH_WIDTH, 8, bits per colour channel
- NUM_CH, 3, channels per pixel; channel 0 is in the LSBs
- CKSUM_W, 32, checksum width
- CONTINUOUS, 0, 1 = re-arm automatically after each frame; 0 = hold in DONE until clear
- pixclk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- valid  in  1  pixel qualifier
- iData  in  NUM_CH*CH_WIDTH  pixel data
- clear  in  1  synchronous re-arm / error clear
- x_coord  out  clog2(IMG_WIDTH)  X position of the next pixel
- y_coord  out  clog2(IMG_HEIGHT)  Y position of the next pixel
- line_done  out  1  one-cycle strobe on the last pixel of each line
- frame_done  out  1  one-cycle strobe on the last pixel of each frame
- busy  out  1  frame in progress (state ACTIVE)
- frame_cnt  out  16  completed frames, wraps modulo 2^16
- checksum  out  CKSUM_W  checksum of the last completed frame
- overrun_err  out  1  sticky: pixel received in DONE
- overrun_cnt  out  16  pixels received in DONE, saturates at 0xFFFF

## Operation
- Input stage: valid and iData are registered every cycle with no enable (v_r, d_r). All processing uses v_r/d_r.
- States: IDLE, ACTIVE, DONE. Reset state is IDLE.
- IDLE → ACTIVE on the first v_r pixel. That pixel is processed as (0,0).
- Pixel processing (IDLE or ACTIVE, v_r=1):
  - acc += sum of the NUM_CH channels of d_r, each zero-extended, modulo 2^CKSUM_W.
  - x_coord increments.
  - At x_coord=IMG_WIDTH-1: x_coord←0, line_done pulses, y_coord increments.
  - At x_coord=IMG_WIDTH-1 and y_coord=IMG_HEIGHT-1:
    - y_coord←0 and frame_done pulses together with line_done.
    - checksum←acc+current pixel sum; acc←0.
    - frame_cnt increments.
    - Next state is DONE if CONTINUOUS=0, otherwise IDLE.
- v_r=0 cycles are gaps. Counters and acc hold.
- DONE: pixels are not accumulated and coordinates hold at (0,0). Each v_r pixel sets overrun_err and increments overrun_cnt, saturating.
- clear (registered-domain, evaluated each cycle):
  - Next state is IDLE.
  - x, y, acc, overrun_err and overrun_cnt are zeroed.
  - checksum and frame_cnt are kept.
  - clear with a simultaneous v_r discards that pixel: no accumulation, no overrun count.
- Asynchronous reset mid-frame: everything returns to its reset value immediately, including the input stage. The partial frame is lost.

## Timing
- Reset values: x_coord=0, y_coord=0, line_done=0, frame_done=0, busy=0, frame_cnt=0, checksum=0, overrun_err=0, overrun_cnt=0.
- All outputs are registered.
- Latency: a pixel sampled on valid at edge N updates coordinates and strobes at edge N+1, so they are visible 2 cycles after valid was presented.
- line_done and frame_done are high for exactly one cycle per event. frame_done always coincides with line_done.
- checksum and frame_cnt update on the same edge that raises frame_done.
- busy:
  - Goes 1 on the edge that processes the first pixel of a frame.
  - Goes 0 on the edge that raises frame_done, or on clear.
- With CONTINUOUS=1, back-to-back frames need no gap: the pixel after the last pixel of a frame is (0,0) of the next frame.
- No handshake back-pressure: the monitor always accepts.

## Test plan
- Frame, IMG_WIDTH=4, IMG_HEIGHT=2, NUM_CH=3, all channels=1, 8 contiguous pixels:
  - line_done pulses twice, 4 cycles apart.
  - frame_done coincides with the second line_done.
  - checksum=24, frame_cnt=1, busy falls.
- Gaps: same frame with valid deasserted every other cycle -> identical checksum=24 and coordinates; strobes are delayed but still one cycle wide.
- Overrun, CONTINUOUS=0: after the frame, 3 further pixels -> overrun_err=1, overrun_cnt=3, coordinates stay (0,0), checksum unchanged. Then clear -> overrun_err=0, overrun_cnt=0, frame_cnt still 1.
- Continuous mode, CONTINUOUS=1: 16 contiguous pixels with values 1..16 on channel 0, other channels 0:
  - frame_done pulses twice.
  - checksum reads 36, then 100; frame_cnt=2; overrun_cnt=0.
- Wrap: CH_WIDTH=8, CKSUM_W=8, all channels=0xFF on 8 pixels -> checksum=(24*255) mod 256=0xE8.
- Reset mid-frame: assert reset after 5 pixels -> all outputs 0 immediately. A following full frame gives the correct checksum with no carry-over.
